// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared widths, exception codes and occupancy encoding for the MEM/WB elastic buffer.
package mem_wb_skid_reg_pkg;

    localparam int MWB_DATA_W         = 32;
    localparam int MWB_REG_ADDR_W     = 5;
    localparam int MWB_EXP_W          = 4;
    localparam int MWB_HART_NUM       = 4;
    localparam int MWB_EXP_NO_EXP     = 0;
    localparam int MWB_EXP_MISS_ALIGN = 1;

    // Encoded as {head_v, skid_v}.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

    function automatic occ_e occ_from_count(input logic [1:0] n);
        case (n)
            2'd0:    return OCC_EMPTY;
            2'd1:    return OCC_ONE;
            default: return OCC_FULL;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// MEM-side push bus, WB-side pop bus and per-hart flush for the MEM/WB buffer.
interface mem_wb_skid_reg_if
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int DATA_W     = MWB_DATA_W,
    parameter int REG_ADDR_W = MWB_REG_ADDR_W,
    parameter int EXP_W      = MWB_EXP_W,
    parameter int HART_NUM   = MWB_HART_NUM
);
    logic                  ex_en;
    logic                  ex_ready;
    logic [EXP_W-1:0]      ex_exp_code;
    logic [DATA_W-1:0]     ex_pc;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_gpr_we_;
    logic [HART_NUM-1:0]   ex_hart_st;
    logic [DATA_W-1:0]     out;
    logic                  miss_align;
    logic [HART_NUM-1:0]   flush_hart;
    logic                  wb_ready;
    logic                  mem_en;
    logic [EXP_W-1:0]      mem_exp_code;
    logic [DATA_W-1:0]     mem_pc;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_gpr_we_;
    logic [DATA_W-1:0]     mem_out;
    logic [HART_NUM-1:0]   mem_hart_st;

    modport master (
        output ex_en, ex_exp_code, ex_pc, ex_rd_addr, ex_gpr_we_, ex_hart_st,
               out, miss_align, flush_hart, wb_ready,
        input  ex_ready, mem_en, mem_exp_code, mem_pc, mem_rd_addr,
               mem_gpr_we_, mem_out, mem_hart_st
    );

    modport slave (
        input  ex_en, ex_exp_code, ex_pc, ex_rd_addr, ex_gpr_we_, ex_hart_st,
               out, miss_align, flush_hart, wb_ready,
        output ex_ready, mem_en, mem_exp_code, mem_pc, mem_rd_addr,
               mem_gpr_we_, mem_out, mem_hart_st
    );

endinterface

// File: rtl/mem_wb_entry.sv
// One buffer slot: load with optional miss-align transform, clear to reset values, else hold.
module mem_wb_entry
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int DATA_W         = MWB_DATA_W,
    parameter int REG_ADDR_W     = MWB_REG_ADDR_W,
    parameter int EXP_W          = MWB_EXP_W,
    parameter int HART_NUM       = MWB_HART_NUM,
    parameter int EXP_NO_EXP     = MWB_EXP_NO_EXP,
    parameter int EXP_MISS_ALIGN = MWB_EXP_MISS_ALIGN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic                  miss_align_i,
    input  logic [EXP_W-1:0]      exp_code_i,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  gpr_we_n_i,
    input  logic [DATA_W-1:0]     out_i,
    input  logic [HART_NUM-1:0]   hart_st_i,
    output logic [EXP_W-1:0]      exp_code_o,
    output logic [DATA_W-1:0]     pc_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  gpr_we_n_o,
    output logic [DATA_W-1:0]     out_o,
    output logic [HART_NUM-1:0]   hart_st_o
);

    logic [EXP_W-1:0]      exp_code_q, exp_code_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  gpr_we_n_q, gpr_we_n_d;
    logic [DATA_W-1:0]     out_q, out_d;
    logic [HART_NUM-1:0]   hart_st_q, hart_st_d;

    // Load wins over clear so a killed slot can be refilled in the same cycle.
    always_comb begin
        exp_code_d = exp_code_q;
        pc_d       = pc_q;
        rd_addr_d  = rd_addr_q;
        gpr_we_n_d = gpr_we_n_q;
        out_d      = out_q;
        hart_st_d  = hart_st_q;
        if (load_i) begin
            pc_d      = pc_i;
            hart_st_d = hart_st_i;
            if (miss_align_i) begin
                exp_code_d = EXP_W'(EXP_MISS_ALIGN);
                rd_addr_d  = '0;
                gpr_we_n_d = 1'b1;
                out_d      = '0;
            end else begin
                exp_code_d = exp_code_i;
                rd_addr_d  = rd_addr_i;
                gpr_we_n_d = gpr_we_n_i;
                out_d      = out_i;
            end
        end else if (clear_i) begin
            exp_code_d = EXP_W'(EXP_NO_EXP);
            pc_d       = '0;
            rd_addr_d  = '0;
            gpr_we_n_d = 1'b1;
            out_d      = '0;
            hart_st_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_code_q <= EXP_W'(EXP_NO_EXP);
            pc_q       <= '0;
            rd_addr_q  <= '0;
            gpr_we_n_q <= 1'b1;
            out_q      <= '0;
            hart_st_q  <= '0;
        end else begin
            exp_code_q <= exp_code_d;
            pc_q       <= pc_d;
            rd_addr_q  <= rd_addr_d;
            gpr_we_n_q <= gpr_we_n_d;
            out_q      <= out_d;
            hart_st_q  <= hart_st_d;
        end
    end

    assign exp_code_o = exp_code_q;
    assign pc_o       = pc_q;
    assign rd_addr_o  = rd_addr_q;
    assign gpr_we_n_o = gpr_we_n_q;
    assign out_o      = out_q;
    assign hart_st_o  = hart_st_q;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB two-entry skid buffer with registered ready, per-hart flush and compaction.
//   state     | meaning
//   OCC_EMPTY | no valid entry, mem_en=0
//   OCC_ONE   | head valid, skid empty, ex_ready=1
//   OCC_FULL  | head and skid valid, ex_ready=0
module mem_wb_skid_reg
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int DATA_W         = MWB_DATA_W,
    parameter int REG_ADDR_W     = MWB_REG_ADDR_W,
    parameter int EXP_W          = MWB_EXP_W,
    parameter int HART_NUM       = MWB_HART_NUM,
    parameter int EXP_NO_EXP     = MWB_EXP_NO_EXP,
    parameter int EXP_MISS_ALIGN = MWB_EXP_MISS_ALIGN
) (
    input  logic               clk,
    input  logic               reset,
    mem_wb_skid_reg_if.slave   bus
);

    occ_e occ_q, occ_d;
    logic ex_ready_q, ex_ready_d;

    logic                  head_v, skid_v;
    logic                  push, pop;
    logic                  kill_h, kill_s, kill_p;
    logic                  h_stay, s_live, p_live;
    logic                  head_load, head_clear, skid_load, skid_clear;
    logic [1:0]            count;

    logic [EXP_W-1:0]      h_exp, s_exp, hsrc_exp;
    logic [DATA_W-1:0]     h_pc, s_pc, hsrc_pc;
    logic [REG_ADDR_W-1:0] h_rd, s_rd, hsrc_rd;
    logic                  h_we_n, s_we_n, hsrc_we_n, hsrc_ma;
    logic [DATA_W-1:0]     h_out, s_out, hsrc_out;
    logic [HART_NUM-1:0]   h_hart, s_hart, hsrc_hart;

    assign head_v = occ_q[1];
    assign skid_v = occ_q[0];

    always_comb begin
        push   = bus.ex_en & ex_ready_q;
        pop    = head_v & bus.wb_ready;
        kill_h = head_v & (|(h_hart & bus.flush_hart));
        kill_s = skid_v & (|(s_hart & bus.flush_hart));
        kill_p = |(bus.ex_hart_st & bus.flush_hart);

        // Survivors in FIFO order: head, skid, incoming. First goes to head, second to skid.
        h_stay = head_v & ~kill_h & ~pop;
        s_live = skid_v & ~kill_s;
        p_live = push & ~kill_p;

        head_load  = ~h_stay & (s_live | p_live);
        head_clear = ~h_stay & ~head_load;
        skid_load  = p_live & (h_stay ^ s_live);
        skid_clear = ~(h_stay & s_live) & ~skid_load;

        count = {1'b0, h_stay} + {1'b0, s_live} + {1'b0, p_live};
        occ_d = occ_from_count(count);
        ex_ready_d = (occ_d != OCC_FULL);

        hsrc_exp  = s_live ? s_exp  : bus.ex_exp_code;
        hsrc_pc   = s_live ? s_pc   : bus.ex_pc;
        hsrc_rd   = s_live ? s_rd   : bus.ex_rd_addr;
        hsrc_we_n = s_live ? s_we_n : bus.ex_gpr_we_;
        hsrc_out  = s_live ? s_out  : bus.out;
        hsrc_hart = s_live ? s_hart : bus.ex_hart_st;
        hsrc_ma   = ~s_live & bus.miss_align;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= OCC_EMPTY;
            ex_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            ex_ready_q <= ex_ready_d;
        end
    end

    mem_wb_entry #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .EXP_W(EXP_W), .HART_NUM(HART_NUM),
        .EXP_NO_EXP(EXP_NO_EXP), .EXP_MISS_ALIGN(EXP_MISS_ALIGN)
    ) u_head (
        .clk(clk), .reset(reset),
        .load_i(head_load), .clear_i(head_clear), .miss_align_i(hsrc_ma),
        .exp_code_i(hsrc_exp), .pc_i(hsrc_pc), .rd_addr_i(hsrc_rd),
        .gpr_we_n_i(hsrc_we_n), .out_i(hsrc_out), .hart_st_i(hsrc_hart),
        .exp_code_o(h_exp), .pc_o(h_pc), .rd_addr_o(h_rd),
        .gpr_we_n_o(h_we_n), .out_o(h_out), .hart_st_o(h_hart)
    );

    mem_wb_entry #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .EXP_W(EXP_W), .HART_NUM(HART_NUM),
        .EXP_NO_EXP(EXP_NO_EXP), .EXP_MISS_ALIGN(EXP_MISS_ALIGN)
    ) u_skid (
        .clk(clk), .reset(reset),
        .load_i(skid_load), .clear_i(skid_clear), .miss_align_i(bus.miss_align),
        .exp_code_i(bus.ex_exp_code), .pc_i(bus.ex_pc), .rd_addr_i(bus.ex_rd_addr),
        .gpr_we_n_i(bus.ex_gpr_we_), .out_i(bus.out), .hart_st_i(bus.ex_hart_st),
        .exp_code_o(s_exp), .pc_o(s_pc), .rd_addr_o(s_rd),
        .gpr_we_n_o(s_we_n), .out_o(s_out), .hart_st_o(s_hart)
    );

    assign bus.ex_ready     = ex_ready_q;
    assign bus.mem_en       = head_v;
    assign bus.mem_exp_code = h_exp;
    assign bus.mem_pc       = h_pc;
    assign bus.mem_rd_addr  = h_rd;
    assign bus.mem_gpr_we_  = h_we_n;
    assign bus.mem_out      = h_out;
    assign bus.mem_hart_st  = h_hart;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed vector bench for mem_wb_skid_reg: streaming, back-pressure, miss-align, flush, reset.
module tb_mem_wb_skid_reg;

    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] o;
        logic [3:0]  hart;
        logic        ma;
        logic [3:0]  fl;
        logic        wb;
    } in_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  exp;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] o;
        logic [3:0]  hart;
        logic        rdy;
    } obs_t;

    typedef struct packed {
        in_t  in;
        obs_t exp;
    } vec_t;

    localparam int NVEC = 25;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    mem_wb_skid_reg_if bus ();

    mem_wb_skid_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic in_t ip(logic en, logic [31:0] pc, logic [4:0] rd, logic we,
                               logic [31:0] o, logic [3:0] hart, logic ma,
                               logic [3:0] fl, logic wb);
        in_t r;
        r.en = en; r.pc = pc; r.rd = rd; r.we = we; r.o = o;
        r.hart = hart; r.ma = ma; r.fl = fl; r.wb = wb;
        return r;
    endfunction

    function automatic obs_t hd(logic [31:0] pc, logic [4:0] rd, logic we, logic [31:0] o,
                                logic [3:0] hart, logic [3:0] e, logic rdy);
        obs_t r;
        r.en = 1'b1; r.exp = e; r.pc = pc; r.rd = rd; r.we = we;
        r.o = o; r.hart = hart; r.rdy = rdy;
        return r;
    endfunction

    function automatic obs_t mt(logic rdy);
        obs_t r;
        r.en = 1'b0; r.exp = 4'd0; r.pc = '0; r.rd = '0; r.we = 1'b1;
        r.o = '0; r.hart = '0; r.rdy = rdy;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.en = bus.mem_en; r.exp = bus.mem_exp_code; r.pc = bus.mem_pc;
        r.rd = bus.mem_rd_addr; r.we = bus.mem_gpr_we_; r.o = bus.mem_out;
        r.hart = bus.mem_hart_st; r.rdy = bus.ex_ready;
        return r;
    endfunction

    task automatic drive(input in_t v);
        bus.ex_en       = v.en;
        bus.ex_exp_code = 4'd0;
        bus.ex_pc       = v.pc;
        bus.ex_rd_addr  = v.rd;
        bus.ex_gpr_we_  = v.we;
        bus.out         = v.o;
        bus.ex_hart_st  = v.hart;
        bus.miss_align  = v.ma;
        bus.flush_hart  = v.fl;
        bus.wb_ready    = v.wb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got en=%0b exp=%0h pc=%h rd=%0d we_=%0b out=%h hart=%b rdy=%0b, want en=%0b exp=%0h pc=%h rd=%0d we_=%0b out=%h hart=%b rdy=%0b",
                     name, act.en, act.exp, act.pc, act.rd, act.we, act.o, act.hart, act.rdy,
                     exp.en, exp.exp, exp.pc, exp.rd, exp.we, exp.o, exp.hart, exp.rdy);
        end
    endtask

    initial begin
        // streaming, wb_ready=1
        vecs[0]  = '{ip(1, 'h100, 1, 0, 'hA0, 4'b0001, 0, 0, 1), hd('h100, 1, 0, 'hA0, 4'b0001, 0, 1)};
        vecs[1]  = '{ip(1, 'h104, 2, 0, 'hA1, 4'b0001, 0, 0, 1), hd('h104, 2, 0, 'hA1, 4'b0001, 0, 1)};
        vecs[2]  = '{ip(1, 'h108, 3, 0, 'hA2, 4'b0001, 0, 0, 1), hd('h108, 3, 0, 'hA2, 4'b0001, 0, 1)};
        vecs[3]  = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 1),               mt(1)};
        // back-pressure: third push refused, drain in order
        vecs[4]  = '{ip(1, 'h200, 4, 0, 'hB0, 4'b0010, 0, 0, 0), hd('h200, 4, 0, 'hB0, 4'b0010, 0, 1)};
        vecs[5]  = '{ip(1, 'h204, 5, 0, 'hB1, 4'b0010, 0, 0, 0), hd('h200, 4, 0, 'hB0, 4'b0010, 0, 0)};
        vecs[6]  = '{ip(1, 'h208, 6, 0, 'hB2, 4'b0010, 0, 0, 0), hd('h200, 4, 0, 'hB0, 4'b0010, 0, 0)};
        vecs[7]  = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 1),               hd('h204, 5, 0, 'hB1, 4'b0010, 0, 1)};
        vecs[8]  = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 1),               mt(1)};
        // miss-align capture transform, held under wb_ready=0
        vecs[9]  = '{ip(1, 'h300, 7, 0, 'hDEAD, 4'b0100, 1, 0, 0), hd('h300, 0, 1, 0, 4'b0100, 1, 1)};
        vecs[10] = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 0),                 hd('h300, 0, 1, 0, 4'b0100, 1, 1)};
        vecs[11] = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 1),                 mt(1)};
        // flush head hart, skid compacts into head
        vecs[12] = '{ip(1, 'h400, 8, 0, 'hC0, 4'b0001, 0, 0, 0), hd('h400, 8, 0, 'hC0, 4'b0001, 0, 1)};
        vecs[13] = '{ip(1, 'h404, 9, 0, 'hC1, 4'b0010, 0, 0, 0), hd('h400, 8, 0, 'hC0, 4'b0001, 0, 0)};
        vecs[14] = '{ip(0, 0, 0, 1, 0, 0, 0, 4'b0001, 0),         hd('h404, 9, 0, 'hC1, 4'b0010, 0, 1)};
        vecs[15] = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 1),               mt(1)};
        // killed push into empty buffer
        vecs[16] = '{ip(1, 'h500, 10, 0, 'hC2, 4'b0100, 0, 4'b0100, 0), mt(1)};
        vecs[17] = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 0),                     mt(1)};
        // pop head while skid is flushed
        vecs[18] = '{ip(1, 'h600, 10, 0, 'hD0, 4'b0001, 0, 0, 0), hd('h600, 10, 0, 'hD0, 4'b0001, 0, 1)};
        vecs[19] = '{ip(1, 'h604, 11, 0, 'hD1, 4'b1000, 0, 0, 0), hd('h600, 10, 0, 'hD0, 4'b0001, 0, 0)};
        vecs[20] = '{ip(0, 0, 0, 1, 0, 0, 0, 4'b1000, 1),         mt(1)};
        // head killed while surviving misaligned push replaces it
        vecs[21] = '{ip(1, 'h700, 12, 0, 'hE0, 4'b0010, 0, 0, 0),       hd('h700, 12, 0, 'hE0, 4'b0010, 0, 1)};
        vecs[22] = '{ip(1, 'h704, 13, 0, 'hE1, 4'b0001, 1, 4'b0010, 1), hd('h704, 0, 1, 0, 4'b0001, 1, 1)};
        vecs[23] = '{ip(0, 0, 0, 1, 0, 0, 0, 0, 1),                     mt(1)};
        // flush beats miss-align on the incoming entry
        vecs[24] = '{ip(1, 'h710, 14, 0, 'hE2, 4'b0100, 1, 4'b0100, 0), mt(1)};

        reset = 1'b1;
        drive(ip(0, 0, 0, 1, 0, 0, 0, 0, 0));
        step();
        step();
        check("reset_state", mt(1));
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].in);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset while FULL, with a live push and wb_ready high
        drive(ip(1, 'h800, 15, 0, 'hF0, 4'b0001, 0, 0, 0));
        step();
        drive(ip(1, 'h804, 16, 0, 'hF1, 4'b0001, 0, 0, 0));
        step();
        check("pre_reset_full", hd('h800, 15, 0, 'hF0, 4'b0001, 0, 0));
        reset = 1'b1;
        drive(ip(1, 'h808, 17, 0, 'hF2, 4'b0001, 0, 0, 1));
        step();
        check("reset_mid_full", mt(1));
        reset = 1'b0;
        drive(ip(0, 0, 0, 1, 0, 0, 0, 0, 1));
        step();
        check("post_reset_empty", mt(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM/WB pipeline register for the multi-hart core. Replaces the single stall/flush register with a 2-entry valid/ready elastic buffer.
- Sits between the MEM stage (memory access result plus EX/MEM fields) and WB.
- Adds per-hart selective flush, decoupled back-pressure without a combinational ready path, and miss-align exception injection at capture.

Parameters:
DATA_W, 32, width of pc and memory/ALU result
REG_ADDR_W, 5, GPR address width
EXP_W, 4, exception code width
HART_NUM, 4, number of harts; hart state is one-hot of this width
EXP_NO_EXP, 0, "no exception" code
EXP_MISS_ALIGN, 1, misalignment exception code

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ex_en  in  1  upstream entry valid
ex_ready  out  1  buffer can accept an entry this cycle
ex_exp_code  in  EXP_W  exception code
ex_pc  in  DATA_W  instruction pc
ex_rd_addr  in  REG_ADDR_W  GPR write address
ex_gpr_we_  in  1  GPR write enable, active-low
ex_hart_st  in  HART_NUM  one-hot owning hart
out  in  DATA_W  memory access result
miss_align  in  1  misaligned access on the incoming entry
flush_hart  in  HART_NUM  kill all entries of the marked harts
wb_ready  in  1  WB consumes head entry this cycle
mem_en  out  1  head entry valid
mem_exp_code  out  EXP_W  head exception code
mem_pc  out  DATA_W  head pc
mem_rd_addr  out  REG_ADDR_W  head GPR address
mem_gpr_we_  out  1  head GPR write enable, active-low
mem_out  out  DATA_W  head result
mem_hart_st  out  HART_NUM  head hart state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled on the rising edge of clk.
- Storage: a head register drives the mem_* outputs. A skid register sits behind it. Occupancy is EMPTY, ONE or FULL, encoded as head_v/skid_v.
- Reset values:
  - mem_en=0, mem_exp_code=EXP_NO_EXP, mem_pc=0, mem_rd_addr=0, mem_gpr_we_=1, mem_out=0, mem_hart_st=0.
  - Skid register cleared the same way; ex_ready=1.
  - Reset overrides all other inputs, including mid-transfer.
- ex_ready: registered, equal to !skid_v. It is never a combinational function of wb_ready.
- Handshakes:
  - push = ex_en & ex_ready.
  - pop = mem_en & wb_ready.
- Capture transform:
  - miss_align=1 on push: the entry is stored with exp_code=EXP_MISS_ALIGN, rd_addr=0, gpr_we_=1, out=0. pc and hart_st pass through.
  - Otherwise all fields are stored as given.
- Flush:
  - An entry is killed when (hart_st & flush_hart) != 0.
  - Applies in the same cycle to head, skid and the incoming push.
  - A killed slot gets reset values. A killed push is not stored but still counts as accepted.
  - Flush has priority over pop and over miss_align.
- Next-state rules, applied after kills, in order head, skid, incoming:
  - EMPTY: push → head; state ONE.
  - ONE, no pop: push → skid; state FULL.
  - ONE, pop: push → head (zero-bubble streaming), else EMPTY.
  - FULL, pop: skid → head; state ONE.
  - FULL, no pop: hold. ex_ready is already 0, so no push can occur.
  - Killed head with surviving skid: skid moves to head in the same cycle (compaction).
- Latency: 1 cycle from push to mem_en. Sustained throughput is 1 entry/cycle when wb_ready=1.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- Held outputs: while mem_en=1 and wb_ready=0, the mem_* outputs hold stable unless that head entry is flushed.
- Skid ready recovery: ex_ready returns to 1 the cycle after the skid empties.

Decomposition:
- Shared package/defines file holds EXP_NO_EXP, EXP_MISS_ALIGN, the hart-state width and the entry field widths. Reuse the existing exception-code and hart-state defines.
- One sub-module is natural: mem_wb_entry, a single slot register with load, kill and reset, plus the capture-transform mux. Instantiate it twice, as head and skid.

Test Plan:
- Reset mid-FULL: fill two entries with wb_ready=0, assert reset → next cycle mem_en=0, mem_gpr_we_=1, mem_exp_code=0, ex_ready=1.
- Streaming: wb_ready=1, push pc=0x100, 0x104, 0x108 on consecutive cycles → mem_pc shows 0x100, 0x104, 0x108 on cycles 1-3; ex_ready stays 1.
- Back-pressure: wb_ready=0, push 0x200, 0x204 → ex_ready=0 after the second push; a third ex_en is not accepted. Raise wb_ready → 0x200 then 0x204 pop in order, and ex_ready=1 one cycle after the skid empties.
- Miss align: push rd=7, gpr_we_=0, out=0xDEAD with miss_align=1 → mem_exp_code=1, mem_rd_addr=0, mem_gpr_we_=1, mem_out=0, pc preserved.
- Selective flush with compaction: FULL with head hart 0001 and skid hart 0010, flush_hart=0001 → next cycle head holds the former skid entry (hart 0010) and state is ONE.
- Flush on push: incoming hart 0100 with flush_hart=0100 and EMPTY → mem_en stays 0 and no entry is stored.
